// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP sequencer.
package xadc_pkg;

    // Width of each committed ADC code (upper 12 bits of the DRP word).
    localparam int XADC_CODE_W = 12;

    // Default DRP status-register addresses.
    localparam logic [6:0] XADC_ADDR_TEMP   = 7'h00;
    localparam logic [6:0] XADC_ADDR_VCCINT = 7'h01;
    localparam logic [6:0] XADC_ADDR_VCCAUX = 7'h02;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_COMMIT = 3'd4
    } seq_state_e;

endpackage

// File: rtl/xadc_drp_sequencer_period_tick.sv
// Free-running wrap counter 0..PERIOD_CYCLES-1; tick_o is high on the last count.
module period_tick #(
    parameter int PERIOD_CYCLES = 100000000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap to zero after the last value.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Scheduled DRP reader: once per period reads temperature, VCCINT and VCCAUX,
// then commits all three 12-bit codes together with a one-cycle valid strobe.
// DRP handshake: drp_den_o is a single-cycle request carrying drp_daddr_o; the
// XADC answers later with a single-cycle drp_drdy_i qualifying drp_do_i, which is
// only sampled while waiting for that answer.
module xadc_drp_sequencer
    import xadc_pkg::*;
#(
    parameter int         PERIOD_CYCLES  = 100000000,
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [6:0] ADDR_TEMP      = XADC_ADDR_TEMP,
    parameter logic [6:0] ADDR_VCCINT    = XADC_ADDR_VCCINT,
    parameter logic [6:0] ADDR_VCCAUX    = XADC_ADDR_VCCAUX
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic [6:0]             drp_daddr_o,
    output logic                   drp_den_o,
    input  logic [15:0]            drp_do_i,
    input  logic                   drp_drdy_i,
    output logic [XADC_CODE_W-1:0] temp_code_o,
    output logic [XADC_CODE_W-1:0] vccint_code_o,
    output logic [XADC_CODE_W-1:0] vccaux_code_o,
    output logic                   sample_valid_o,
    output logic                   busy_o,
    output logic                   timeout_err_o,
    output logic                   overrun_err_o,
    output logic [2:0]             dbg_state_o
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_e state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [TW-1:0] to_q, to_d;
    logic [2:0][XADC_CODE_W-1:0] shadow_q, shadow_d;
    logic [2:0][XADC_CODE_W-1:0] codes_q, codes_d;
    logic den_q, den_d;
    logic [6:0] daddr_q, daddr_d;
    logic valid_q, valid_d;
    logic busy_q, busy_d;
    logic to_err_q, to_err_d;
    logic ov_err_q, ov_err_d;
    logic tick;
    logic [XADC_CODE_W-1:0] cur_code;
    logic [XADC_CODE_W-1:0] wr_code;
    logic unused_do_lsbs;

    // The low nibble of the DRP word is below the ADC resolution.
    assign unused_do_lsbs = ^drp_do_i[3:0];

    period_tick #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tick_o(tick)
    );

    // Committed code of the channel being read (kept on timeout) and the value
    // the shadow receives when the WAIT state resolves.
    always_comb begin
        case (idx_q)
            2'd0:    cur_code = codes_q[0];
            2'd1:    cur_code = codes_q[1];
            default: cur_code = codes_q[2];
        endcase
        wr_code = drp_drdy_i ? drp_do_i[15:4] : cur_code;
    end

    // Next-state logic; registered outputs are derived from the next state.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        to_d     = to_q;
        shadow_d = shadow_q;
        codes_d  = codes_q;
        to_err_d = to_err_q;
        ov_err_d = ov_err_q;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    idx_d   = 2'd0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                to_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // drdy has priority over an expiring timeout on the same cycle.
                if (drp_drdy_i || (to_q == TO_LAST)) begin
                    if (!drp_drdy_i) begin
                        to_err_d = 1'b1;
                    end
                    case (idx_q)
                        2'd0:    shadow_d[0] = wr_code;
                        2'd1:    shadow_d[1] = wr_code;
                        default: shadow_d[2] = wr_code;
                    endcase
                    state_d = ST_NEXT;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_NEXT: begin
                if (idx_q == 2'd2) begin
                    codes_d = shadow_q;
                    state_d = ST_COMMIT;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A period tick that finds a round still running is dropped and flagged.
        if (tick && (state_q != ST_IDLE)) begin
            ov_err_d = 1'b1;
        end

        den_d = (state_d == ST_ISSUE);
        if (den_d) begin
            case (idx_d)
                2'd0:    daddr_d = ADDR_TEMP;
                2'd1:    daddr_d = ADDR_VCCINT;
                default: daddr_d = ADDR_VCCAUX;
            endcase
        end else begin
            daddr_d = '0;
        end
        valid_d = (state_d == ST_COMMIT);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            to_q     <= '0;
            shadow_q <= '0;
            codes_q  <= '0;
            den_q    <= 1'b0;
            daddr_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            to_err_q <= 1'b0;
            ov_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            to_q     <= to_d;
            shadow_q <= shadow_d;
            codes_q  <= codes_d;
            den_q    <= den_d;
            daddr_q  <= daddr_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            to_err_q <= to_err_d;
            ov_err_q <= ov_err_d;
        end
    end

    assign drp_den_o      = den_q;
    assign drp_daddr_o    = daddr_q;
    assign temp_code_o    = codes_q[0];
    assign vccint_code_o  = codes_q[1];
    assign vccaux_code_o  = codes_q[2];
    assign sample_valid_o = valid_q;
    assign busy_o         = busy_q;
    assign timeout_err_o  = to_err_q;
    assign overrun_err_o  = ov_err_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Bench for xadc_drp_sequencer: DRP responder plus a round-level timing model.
module tb_xadc_drp_sequencer;

    localparam int PERIOD = 64;
    localparam int TMO    = 64;
    localparam int NEVER  = 32'h7fffffff;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i      = 1'b1;
    logic [15:0] drp_do_i   = 16'h0;
    logic        drp_drdy_i = 1'b0;
    logic [6:0]  drp_daddr_o;
    logic        drp_den_o;
    logic [11:0] temp_code_o, vccint_code_o, vccaux_code_o;
    logic        sample_valid_o, busy_o, timeout_err_o, overrun_err_o;
    logic [2:0]  dbg_state_o;

    xadc_drp_sequencer #(
        .PERIOD_CYCLES (PERIOD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .drp_daddr_o   (drp_daddr_o),
        .drp_den_o     (drp_den_o),
        .drp_do_i      (drp_do_i),
        .drp_drdy_i    (drp_drdy_i),
        .temp_code_o   (temp_code_o),
        .vccint_code_o (vccint_code_o),
        .vccaux_code_o (vccaux_code_o),
        .sample_valid_o(sample_valid_o),
        .busy_o        (busy_o),
        .timeout_err_o (timeout_err_o),
        .overrun_err_o (overrun_err_o),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;

    // Round model: computed once per accepted tick from the channel delays.
    bit          act = 1'b0;
    int          t0 = 0;
    int          den_cyc[3];
    int          valid_cyc = 0;
    logic [11:0] new_code[3];
    logic [11:0] m_code[3];
    int          to_from = NEVER;
    int          ov_from = NEVER;
    int          rounds_done = 0;
    int          obs_valid_cyc = -1;
    logic [11:0] exp_q[$];

    // Responder configuration: per-channel delay (above TMO = never answer) and data.
    int          dly[3];
    logic [15:0] dat[3];
    bit          spur_req = 1'b0;
    int          pend = 0;
    logic [15:0] pend_dat = 16'h0;

    task automatic check(input string tag, input logic [31:0] act_v, input logic [31:0] exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act_v, exp_v, cyc);
        end
    endtask

    task automatic model_start(input int t);
        int c;
        c   = t + 1;
        act = 1'b1;
        t0  = t;
        for (int k = 0; k < 3; k++) begin
            den_cyc[k] = c;
            if (dly[k] <= TMO) begin
                new_code[k] = dat[k][15:4];
                c = c + 2 + dly[k];
            end else begin
                new_code[k] = m_code[k];
                if (c + TMO + 1 < to_from) to_from = c + TMO + 1;
                c = c + TMO + 2;
            end
        end
        valid_cyc = c;
    endtask

    // One clock cycle: compare outputs at the negedge, then drive the DRP inputs.
    task automatic step();
        bit         e_den, e_valid, e_busy;
        logic [6:0] e_addr;
        int         ix;
        @(negedge clk);
        cyc++;
        if (rst_i) begin
            act = 1'b0;
            for (int k = 0; k < 3; k++) m_code[k] = 12'h000;
            to_from = NEVER;
            ov_from = NEVER;
            base    = cyc;
        end
        e_den  = 1'b0;
        e_addr = 7'h00;
        for (int k = 0; k < 3; k++) begin
            if (act && den_cyc[k] == cyc) begin
                e_den  = 1'b1;
                e_addr = 7'(k);
            end
        end
        e_valid = act && (cyc == valid_cyc);
        if (e_valid) begin
            for (int k = 0; k < 3; k++) m_code[k] = new_code[k];
            rounds_done++;
        end
        e_busy = act && (cyc > t0) && (cyc <= valid_cyc);
        if (sample_valid_o) obs_valid_cyc = cyc;

        check("den", 32'(drp_den_o), 32'(e_den));
        if (e_den || drp_den_o) check("daddr", 32'(drp_daddr_o), 32'(e_addr));
        check("busy", 32'(busy_o), 32'(e_busy));
        check("sample_valid", 32'(sample_valid_o), 32'(e_valid));
        check("temp_code", 32'(temp_code_o), 32'(m_code[0]));
        check("vccint_code", 32'(vccint_code_o), 32'(m_code[1]));
        check("vccaux_code", 32'(vccaux_code_o), 32'(m_code[2]));
        check("timeout_err", 32'(timeout_err_o), 32'(cyc >= to_from));
        check("overrun_err", 32'(overrun_err_o), 32'(cyc >= ov_from));

        if ((cyc - base) % PERIOD == PERIOD - 1) begin
            if (e_busy) begin
                if (cyc + 1 < ov_from) ov_from = cyc + 1;
            end else begin
                model_start(cyc);
            end
        end else if (act && cyc >= valid_cyc) begin
            act = 1'b0;
        end

        // DRP responder
        drp_drdy_i = 1'b0;
        drp_do_i   = 16'($urandom);
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                drp_drdy_i = 1'b1;
                drp_do_i   = pend_dat;
            end
        end
        if (spur_req) begin
            drp_drdy_i = 1'b1;
            drp_do_i   = 16'hFFF0;
            spur_req   = 1'b0;
        end
        if (drp_den_o && drp_daddr_o < 7'd3) begin
            ix = int'(drp_daddr_o);
            if (dly[ix] <= TMO) begin
                pend     = dly[ix];
                pend_dat = dat[ix];
            end
        end
    endtask

    task automatic run_until_commit();
        int target;
        target = rounds_done + 1;
        for (int n = 0; n < 400 && rounds_done < target; n++) step();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 400 && act; n++) step();
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    task automatic set_round(input int d0, input int d1, input int d2);
        dly[0] = d0;
        dly[1] = d1;
        dly[2] = d2;
        for (int k = 0; k < 3; k++) dat[k] = 16'($urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [11:0] keep;
        set_round(1, 1, 1);
        repeat (3) step();
        rst_i = 1'b0;
        check("rst_den", 32'(drp_den_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_temp", 32'(temp_code_o), 32'h0);

        // Nominal round, D=2
        dly[0] = 2; dly[1] = 2; dly[2] = 2;
        dat[0] = 16'hA5C0; dat[1] = 16'h5550; dat[2] = 16'h9990;
        exp_q.push_back(12'hA5C); exp_q.push_back(12'h555); exp_q.push_back(12'h999);
        run_until_commit();
        check("nom_temp", 32'(temp_code_o), 32'(exp_q.pop_front()));
        check("nom_vccint", 32'(vccint_code_o), 32'(exp_q.pop_front()));
        check("nom_vccaux", 32'(vccaux_code_o), 32'(exp_q.pop_front()));
        check("nom_latency", 32'(obs_valid_cyc - t0), 32'd13);

        // Randomized rounds
        repeat (6) begin
            wait_idle();
            set_round($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(1, 20));
            run_until_commit();
        end

        // VCCINT read never answered
        wait_idle();
        keep = m_code[1];
        set_round($urandom_range(1, 8), 999, $urandom_range(1, 8));
        exp_q.push_back(dat[0][15:4]);
        run_until_commit();
        check("to_err_set", 32'(timeout_err_o), 32'h1);
        check("to_vccint_kept", 32'(vccint_code_o), 32'(keep));
        check("to_temp_upd", 32'(temp_code_o), 32'(exp_q.pop_front()));

        // Clear sticky errors, then drdy exactly on the timeout cycle
        pulse_reset();
        check("rst_to_err", 32'(timeout_err_o), 32'h0);
        set_round(TMO, 1, TMO);
        exp_q.push_back(dat[2][15:4]);
        run_until_commit();
        check("simul_to_err", 32'(timeout_err_o), 32'h0);
        check("simul_vccaux", 32'(vccaux_code_o), 32'(exp_q.pop_front()));

        // Spurious drdy while idle
        keep = m_code[0];
        repeat (2) step();
        spur_req = 1'b1;
        repeat (3) step();
        check("spur_temp", 32'(temp_code_o), 32'(keep));

        // Overrun: round longer than the period
        wait_idle();
        set_round(25, 25, 25);
        run_until_commit();
        check("ovr_err", 32'(overrun_err_o), 32'h1);
        repeat (60) step();

        // Reset during the second read's WAIT, late drdy afterwards
        wait_idle();
        set_round(5, 5, 5);
        for (int n = 0; n < 400 && !(act && cyc == den_cyc[1] + 2); n++) step();
        pulse_reset();
        check("mid_busy", 32'(busy_o), 32'h0);
        check("mid_den", 32'(drp_den_o), 32'h0);
        check("mid_ovr", 32'(overrun_err_o), 32'h0);
        check("mid_vccint", 32'(vccint_code_o), 32'h0);
        set_round(3, 3, 3);
        exp_q.push_back(dat[1][15:4]);
        run_until_commit();
        check("post_rst_vccint", 32'(vccint_code_o), 32'(exp_q.pop_front()));
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound
    initial begin
        #2000000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xadc_drp_sequencer.md
# xadc_drp_sequencer

Periodic sequencer that owns the XADC dynamic reconfiguration port (DRP). It replaces free-running `eoc`-driven reads with a scheduled round of three register reads: temperature, VCCINT and VCCAUX. Results are committed together as 12-bit codes with a one-cycle valid strobe. The block sits between the XADC wizard instance and the display and scaling logic, which consume `temp_code` once per period.

## Interface
- `PERIOD_CYCLES`, default 100000000: clock cycles between round starts (1 s at 100 MHz); minimum 16.
- `TIMEOUT_CYCLES`, default 64: maximum cycles to wait for `drdy` after a `den` pulse.
- `ADDR_TEMP`, default 7'h00: DRP address of the temperature status register.
- `ADDR_VCCINT`, default 7'h01: DRP address of VCCINT.
- `ADDR_VCCAUX`, default 7'h02: DRP address of VCCAUX.
- `clk` in 1: single system clock, also drives XADC `dclk_in`.
- `rst` in 1: synchronous, active-high reset.
- `drp_daddr` out 7: DRP address; valid only while `drp_den` is high.
- `drp_den` out 1: one-cycle DRP read enable.
- `drp_do` in 16: DRP read data; sampled only when `drp_drdy` is high.
- `drp_drdy` in 1: DRP data-ready strobe.
- `temp_code` out 12: committed `drp_do[15:4]` from the temperature read.
- `vccint_code` out 12: committed `drp_do[15:4]` from the VCCINT read.
- `vccaux_code` out 12: committed `drp_do[15:4]` from the VCCAUX read.
- `sample_valid` out 1: one-cycle pulse when all three codes update.
- `busy` out 1: high while a round is in progress.
- `timeout_err` out 1: sticky; set when any read times out.
- `overrun_err` out 1: sticky; set when a period tick arrives while busy.

## Operation
- Period counter runs 0..PERIOD_CYCLES-1 and wraps. `tick` asserts on the cycle the counter equals PERIOD_CYCLES-1.
- FSM states are IDLE, ISSUE, WAIT, NEXT and COMMIT.
- IDLE: on `tick`, clear channel index to 0 and go to ISSUE.
- ISSUE: hold `drp_den`=1 with `drp_daddr`=address[idx] for exactly one cycle. Clear the timeout counter. Go to WAIT.
- WAIT, normal path: on `drp_drdy`, capture `drp_do[15:4]` into shadow[idx] and go to NEXT.
- WAIT, timeout: if the counter reaches TIMEOUT_CYCLES-1 without `drdy`, set `timeout_err`, copy the committed value into shadow[idx] (the old value is retained), and go to NEXT.
- NEXT: if idx==2, go to COMMIT; otherwise increment idx and go to ISSUE.
- COMMIT: copy all three shadows to the outputs, pulse `sample_valid`, and return to IDLE.
- `busy` is high in every state except IDLE.
- `tick` while busy: ignored (no queuing) and sets `overrun_err`.
- `drp_drdy` outside WAIT: ignored, with no data capture.
- `drdy` and timeout on the same cycle: `drdy` wins, the data is captured, and no error is set.
- Sticky errors clear only on `rst`.

## Timing
- Reset values:
  - `drp_den`=0, `drp_daddr`=0.
  - All codes 12'h000.
  - `sample_valid`=0, `busy`=0, both errors 0.
  - FSM in IDLE, counters and idx 0.
- `drp_den` goes high on the cycle after `tick`.
- With `drdy` arriving D cycles after `den` (D≥1), one channel takes 2+D cycles (ISSUE + D×WAIT + NEXT).
- `sample_valid` fires 1 cycle after the last NEXT. For D=1, a round is 10 cycles from `tick` to `sample_valid`.
- A timed-out channel takes TIMEOUT_CYCLES+2 cycles.
- `rst` mid-round: the next cycle is IDLE with `den` low. Outputs return to reset values. A late `drdy` after reset is ignored.
- Outputs are registered; no combinational path from `drp_*` inputs to outputs.

## Structure
- Package `xadc_pkg` holds:
  - the FSM state enum;
  - default DRP address constants;
  - the `XADC_CODE_W`=12 width constant.
- Sub-module `period_tick` holds the parameterized wrap counter producing a one-cycle `tick`.
- The sequencer FSM, shadow registers and timeout counter stay in the top module.

## Test plan
- Nominal round: PERIOD=64, DRP model returns 16'hA5C0/16'h5550/16'h9990 with D=2. Required: `temp_code`=12'hA5C, `vccint_code`=12'h555, `vccaux_code`=12'h999, one `sample_valid` pulse 13 cycles after `tick`, and `den` pulses carry addresses 00, 01, 02 in order.
- Timeout: model withholds `drdy` for ADDR_VCCINT only. Required: `timeout_err`=1, `vccint_code` keeps its previous value, and the other two codes update.
- Overrun: PERIOD=16, D=10. Required: `overrun_err`=1, the round completes, and no second round starts until the next `tick` seen in IDLE.
- Spurious and simultaneous: `drdy` pulse while in IDLE leaves codes unchanged. `drdy` on the timeout cycle captures data with `timeout_err`=0.
- Reset mid-WAIT: assert `rst` for one cycle during the second read. Required: all outputs 0 the next cycle, `busy`=0, and a normal round follows on the subsequent tick.
